// File: rtl/mux_pkg.sv
// mux_pkg: shared types and helpers for the handshaked N:1 mux family.
package mux_pkg;

    typedef enum logic {
        MUX_EMPTY = 1'b0,
        MUX_FULL  = 1'b1
    } mux_state_e;

    // Index width that never collapses to zero bits.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_rr_reg_rr_arbiter.sv
// rr_arbiter: one-hot grant plus binary index over a request vector.
// Round-robin from ptr when MUX_NTO1_RR_EN is defined, else fixed priority.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              enable,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  idx
);

    int   c;
    logic found;

`ifndef MUX_NTO1_RR_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef MUX_NTO1_RR_EN
            // ptr < NUM_CH, so one subtraction wraps the search
            c = int'(ptr) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
`else
            c = k;
`endif
            if (enable && !found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = c[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_nto1_rr_reg.sv
// mux_nto1_rr_reg: N:1 handshaked mux, internal arbiter, one-entry output reg.
// Define MUX_NTO1_RR_EN for round-robin; otherwise fixed priority (ch0 highest).
module mux_nto1_rr_reg
    import mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [NUM_CH*DATA_W-1:0] d_in,
    input  logic [NUM_CH-1:0]        valid_in,
    output logic [NUM_CH-1:0]        ready_out,
    output logic [DATA_W-1:0]        y_out,
    output logic [SEL_W-1:0]         sel_out,
    output logic                     valid_out,
    input  logic                     ready_in
);

    mux_state_e        state_q, state_d;
    logic              accept;
    logic              transfer;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  idx;
    logic [SEL_W-1:0]  ptr;
    logic [DATA_W-1:0] y_q;
    logic [SEL_W-1:0]  sel_q;

    // Reset term keeps every ready_out low while reset is held
    assign accept = rst_n_in & ((state_q == MUX_EMPTY) | ready_in);

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req    (valid_in),
        .ptr    (ptr),
        .enable (accept),
        .grant  (grant),
        .idx    (idx)
    );

    assign ready_out = grant & {NUM_CH{accept}};
    assign transfer  = |(valid_in & ready_out);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MUX_EMPTY: if (transfer) state_d = MUX_FULL;
            MUX_FULL:  if (ready_in && !transfer) state_d = MUX_EMPTY;
            default:   state_d = MUX_EMPTY;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= MUX_EMPTY;
            y_q     <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if (transfer) begin
                y_q   <= d_in[idx*DATA_W +: DATA_W];
                sel_q <= idx;
            end
        end
    end

`ifdef MUX_NTO1_RR_EN
    logic [SEL_W-1:0] ptr_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr_q <= '0;
        end else if (transfer) begin
            ptr_q <= (idx == SEL_W'(NUM_CH - 1)) ? '0 : idx + SEL_W'(1);
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    assign y_out     = y_q;
    assign sel_out   = sel_q;
    assign valid_out = (state_q == MUX_FULL);

endmodule
